// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter: FSM states, grant and op encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between icache and dcache.
// MEM_ARB_RR_EN selects round-robin; otherwise dcache has fixed priority.
import mem_arb_pkg::*;

module mem_arb_pick (
  input  logic i_ireq,
  input  logic i_dreq,
`ifdef MEM_ARB_RR_EN
  input  gnt_t i_last,
`endif
  output gnt_t o_gnt
);

`ifdef MEM_ARB_RR_EN
  // Contention goes to whichever side did not win last time.
  assign o_gnt = (i_ireq && i_dreq) ? ((i_last == GNT_I) ? GNT_D : GNT_I)
               : (i_dreq ? GNT_D : GNT_I);
`else
  assign o_gnt = i_dreq ? GNT_D : GNT_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache reads and dcache reads/writes.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: dcache priority).
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   icache_addr,
  input  logic                icache_req,
  output logic [DATA_W-1:0]   icache_rdata,
  output logic                icache_ready,
  input  logic [ADDR_W-1:0]   dcache_addr,
  input  logic [DATA_W-1:0]   dcache_wdata,
  input  logic [DATA_W/8-1:0] dcache_wmask,
  input  logic                dcache_wen,
  input  logic                dcache_ren,
  output logic [DATA_W-1:0]   dcache_rdata,
  output logic                dcache_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_rstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rbusy,
  input  logic                mem_wbusy
);

  localparam int MASK_W = DATA_W/8;

  state_t              r_state;
  gnt_t                r_gnt;
  op_t                 r_op;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [MASK_W-1:0]   r_mem_wmask;
  logic                r_mem_rstrb;
  logic [DATA_W-1:0]   r_icache_rdata;
  logic [DATA_W-1:0]   r_dcache_rdata;
  logic                r_icache_ready;
  logic                r_dcache_ready;

  logic                w_dreq;
  logic                w_any;
  logic                w_busy;
  gnt_t                w_gnt;
  op_t                 w_op;
  logic [ADDR_W-1:0]   w_req_addr;

  assign w_dreq     = dcache_wen | dcache_ren;
  assign w_any      = icache_req | w_dreq;
  assign w_op       = (w_gnt == GNT_D && dcache_wen) ? OP_WR : OP_RD;
  assign w_req_addr = (w_gnt == GNT_D) ? dcache_addr : icache_addr;
  assign w_busy     = (r_op == OP_WR) ? mem_wbusy : mem_rbusy;

`ifdef MEM_ARB_RR_EN
  gnt_t r_last;

  mem_arb_pick u_pick (
    .i_ireq (icache_req),
    .i_dreq (w_dreq),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    r_last <= GNT_I;
    else if (r_state == IDLE && w_any) r_last <= w_gnt;
  end
`else
  mem_arb_pick u_pick (
    .i_ireq (icache_req),
    .i_dreq (w_dreq),
    .o_gnt  (w_gnt)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_gnt          <= GNT_I;
      r_op           <= OP_RD;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_wmask    <= '0;
      r_mem_rstrb    <= 1'b0;
      r_icache_rdata <= '0;
      r_dcache_rdata <= '0;
      r_icache_ready <= 1'b0;
      r_dcache_ready <= 1'b0;
    end else begin
      r_mem_rstrb    <= 1'b0;
      r_mem_wmask    <= '0;
      r_icache_ready <= 1'b0;
      r_dcache_ready <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_gnt      <= w_gnt;
          r_op       <= w_op;
          r_mem_addr <= w_req_addr;
          if (w_gnt == GNT_D) r_mem_wdata <= dcache_wdata;
          // An all-zero mask write touches nothing, so skip the memory port.
          if (w_op == OP_WR && dcache_wmask == '0) begin
            r_dcache_ready <= 1'b1;
            r_state        <= RESP;
          end else begin
            r_mem_rstrb <= (w_op == OP_RD);
            r_mem_wmask <= (w_op == OP_WR) ? dcache_wmask : '0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: if (!w_busy) begin
          if (r_op == OP_RD) begin
            if (r_gnt == GNT_I) r_icache_rdata <= mem_rdata;
            else                r_dcache_rdata <= mem_rdata;
          end
          if (r_gnt == GNT_I) r_icache_ready <= 1'b1;
          else                r_dcache_ready <= 1'b1;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_wmask    = r_mem_wmask;
  assign mem_rstrb    = r_mem_rstrb;
  assign icache_rdata = r_icache_rdata;
  assign icache_ready = r_icache_ready;
  assign dcache_rdata = r_dcache_rdata;
  assign dcache_ready = r_dcache_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected responses, a monitor
// pops them on every ready pulse; a sparse-array memory model serves the bus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] icache_addr = '0;
  logic        icache_req = 1'b0;
  logic [31:0] icache_rdata;
  logic        icache_ready;
  logic [31:0] dcache_addr = '0;
  logic [31:0] dcache_wdata = '0;
  logic [3:0]  dcache_wmask = '0;
  logic        dcache_wen = 1'b0;
  logic        dcache_ren = 1'b0;
  logic [31:0] dcache_rdata;
  logic        dcache_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_rbusy = 1'b0;
  logic        mem_wbusy = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .icache_addr(icache_addr), .icache_req(icache_req),
    .icache_rdata(icache_rdata), .icache_ready(icache_ready),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_wmask(dcache_wmask), .dcache_wen(dcache_wen), .dcache_ren(dcache_ren),
    .dcache_rdata(dcache_rdata), .dcache_ready(dcache_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference memory (what the caches asked for) and physical memory (what the bus did).
  bit [31:0] ref_mem  [bit [31:0]];
  bit [31:0] phys_mem [bit [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
  endfunction

  // Memory model: busy for busy_cfg cycles (random 0..3 when negative).
  int          busy_cfg = 0;
  bit          m_pend = 0;
  int          m_cnt = 0;
  logic [31:0] m_val = '0;
  int          n_rstrb = 0;
  int          n_wr = 0;

  always @(negedge clk) begin
    if (!reset) begin
      m_pend = 0; mem_rbusy = 1'b0; mem_wbusy = 1'b0;
    end else begin
      if (mem_rstrb || mem_wmask != 4'b0) begin
        chk("issue_overlap", 32'(m_pend), 32'd0);
        chk("rstrb_with_wmask", 32'(mem_rstrb && mem_wmask != 4'b0), 32'd0);
      end
      if (m_pend) begin
        if (m_cnt == 0) begin
          mem_rbusy = 1'b0; mem_wbusy = 1'b0; mem_rdata = m_val; m_pend = 0;
        end else m_cnt--;
      end else if (mem_rstrb || mem_wmask != 4'b0) begin
        int nb;
        logic [31:0] v;
        nb = (busy_cfg >= 0) ? busy_cfg : int'($urandom_range(0, 3));
        if (mem_rstrb) begin
          n_rstrb++;
          m_val = phys_rd(mem_addr);
          mem_rbusy = (nb != 0);
        end else begin
          n_wr++;
          v = phys_rd(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_wmask[b]) v[8*b +: 8] = mem_wdata[8*b +: 8];
          phys_mem[mem_addr] = v;
          m_val = $urandom;
          mem_wbusy = (nb != 0);
        end
        mem_rdata = $urandom;
        m_pend = 1;
        m_cnt = nb;
      end
    end
  end

  // Scoreboard
  typedef struct { bit rd; logic [31:0] d; } dexp_t;
  logic [31:0] iq[$];
  dexp_t       dq[$];
  byte         glog[$];

  always @(negedge clk) begin
    if (reset) begin
      if (icache_ready) begin
        glog.push_back("I");
        chk("dual_ready", 32'(dcache_ready), 32'd0);
        if (iq.size() == 0) chk("icache_ready_unexpected", 32'(icache_ready), 32'd0);
        else chk("icache_rdata", icache_rdata, iq.pop_front());
      end
      if (dcache_ready) begin
        glog.push_back("D");
        if (dq.size() == 0) chk("dcache_ready_unexpected", 32'(dcache_ready), 32'd0);
        else begin
          dexp_t e;
          e = dq.pop_front();
          if (e.rd) chk("dcache_rdata", dcache_rdata, e.d);
        end
      end
    end
  end

  task automatic i_read(input logic [31:0] a, output int lat);
    iq.push_back(ref_rd(a));
    @(posedge clk); #1;
    icache_addr = a; icache_req = 1'b1; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!icache_ready && lat < 300);
    if (!icache_ready) chk("icache_timeout", 32'(icache_ready), 32'd1);
    icache_req = 1'b0;
  endtask

  task automatic d_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                      input bit wen, input bit ren, output int lat);
    dexp_t e;
    logic [31:0] v;
    e.rd = !wen && ren;
    e.d  = ref_rd(a);
    if (wen && wm != 4'b0) begin
      v = ref_rd(a);
      for (int b = 0; b < 4; b++) if (wm[b]) v[8*b +: 8] = wd[8*b +: 8];
      ref_mem[a] = v;
    end
    dq.push_back(e);
    @(posedge clk); #1;
    dcache_addr = a; dcache_wdata = wd; dcache_wmask = wm;
    dcache_wen = wen; dcache_ren = ren; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!dcache_ready && lat < 300);
    if (!dcache_ready) chk("dcache_timeout", 32'(dcache_ready), 32'd1);
    dcache_wen = 1'b0; dcache_ren = 1'b0;
  endtask

  task automatic chk_outs_zero(input string p);
    chk({p, "_icache_ready"}, 32'(icache_ready), 32'd0);
    chk({p, "_dcache_ready"}, 32'(dcache_ready), 32'd0);
    chk({p, "_mem_rstrb"}, 32'(mem_rstrb), 32'd0);
    chk({p, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
    chk({p, "_mem_addr"}, mem_addr, 32'd0);
    chk({p, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({p, "_icache_rdata"}, icache_rdata, 32'd0);
    chk({p, "_dcache_rdata"}, dcache_rdata, 32'd0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no end of test, expected finish within 60000 cycles");
    $fatal(1);
  end

  initial begin
    int lat, r0, w0, t;
    logic [31:0] v;
    byte exp_g[4];

    ref_mem[32'h100]  = 32'hDEAD_BEEF;
    phys_mem[32'h100] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk); #1;
    chk_outs_zero("reset");
    reset = 1'b1;

    // Simultaneous requests held high: four grants observed.
`ifdef MEM_ARB_RR_EN
    exp_g[0] = "D"; exp_g[1] = "I"; exp_g[2] = "D"; exp_g[3] = "I";
`else
    exp_g[0] = "D"; exp_g[1] = "D"; exp_g[2] = "D"; exp_g[3] = "D";
`endif
    busy_cfg = 0;
    for (int k = 0; k < 4; k++) begin
      dexp_t e;
      iq.push_back(ref_rd(32'h200));
      e.rd = 1; e.d = ref_rd(32'h2040);
      dq.push_back(e);
    end
    glog.delete();
    @(posedge clk); #1;
    icache_addr = 32'h200; icache_req = 1'b1;
    dcache_addr = 32'h2040; dcache_ren = 1'b1;
    t = 0;
    while (glog.size() < 4 && t < 200) begin @(posedge clk); #1; t++; end
    icache_req = 1'b0; dcache_ren = 1'b0;
    for (int k = 0; k < 4; k++) chk($sformatf("contention_gnt%0d", k), 32'(glog[k]), 32'(exp_g[k]));
    repeat (6) @(posedge clk);
    iq.delete(); dq.delete();

    // icache read with two busy cycles
    busy_cfg = 2; r0 = n_rstrb;
    i_read(32'h100, lat);
    chk("iread_latency", 32'(lat), 32'd5);
    chk("iread_rstrb_count", 32'(n_rstrb - r0), 32'd1);

    // dcache partial write, no busy
    busy_cfg = 0; w0 = n_wr;
    d_op(32'h2000, 32'h1234_5678, 4'b0011, 1, 0, lat);
    chk("dwrite_latency", 32'(lat), 32'd3);
    chk("dwrite_count", 32'(n_wr - w0), 32'd1);
    v = init_val(32'h2000);
    chk("dwrite_mem", phys_rd(32'h2000), {v[31:16], 16'h5678});

    // zero-mask write bypasses memory
    r0 = n_rstrb; w0 = n_wr;
    d_op(32'h2004, 32'hFFFF_FFFF, 4'b0000, 1, 0, lat);
    chk("zmask_latency", 32'(lat), 32'd1);
    chk("zmask_rstrb", 32'(n_rstrb - r0), 32'd0);
    chk("zmask_wr", 32'(n_wr - w0), 32'd0);

    // wen and ren together: write wins
    r0 = n_rstrb; w0 = n_wr;
    d_op(32'h2008, 32'hCAFE_F00D, 4'hF, 1, 1, lat);
    chk("wr_rd_latency", 32'(lat), 32'd3);
    chk("wr_rd_rstrb", 32'(n_rstrb - r0), 32'd0);
    chk("wr_rd_wr", 32'(n_wr - w0), 32'd1);
    chk("wr_rd_mem", phys_rd(32'h2008), 32'hCAFE_F00D);

    // reset while waiting on a busy read
    busy_cfg = 6;
    @(posedge clk); #1;
    icache_addr = 32'h300; icache_req = 1'b1;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; icache_req = 1'b0;
    #1; chk_outs_zero("midreset");
    repeat (2) @(posedge clk);
    #1; reset = 1'b1; busy_cfg = 0;
    i_read(32'h304, lat);
    chk("post_reset_latency", 32'(lat), 32'd3);

    // randomized concurrent traffic
    busy_cfg = -1;
    fork
      begin
        int l;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          i_read({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, l);
        end
      end
      begin
        int l, kind;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(1, 4)) @(posedge clk);
          kind = $urandom_range(0, 3);
          a = 32'h2000 + 32'(4 * $urandom_range(0, 15));
          case (kind)
            0: d_op(a, $urandom, 4'h0, 0, 1, l);
            1: d_op(a, $urandom, 4'($urandom_range(1, 15)), 1, 0, l);
            2: d_op(a, $urandom, 4'h0, 1, 0, l);
            default: d_op(a, $urandom, 4'($urandom_range(1, 15)), 1, 1, l);
          endcase
        end
      end
    join
    repeat (6) @(posedge clk);

    foreach (ref_mem[k]) chk($sformatf("mem_%h", k), phys_rd(k), ref_mem[k]);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing arbiter that shares the single main-memory port between the instruction cache and data cache refill/write paths. Accepts one outstanding transaction per requester, selects a winner, drives the main-memory strobe/mask/busy protocol, and returns one ready pulse with read data to the granted cache. Sits between the icache/dcache memory-side ports and the SoC memory interface, replacing direct cache-to-memory wiring.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (mask width DATA_W/8)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- icache_addr  in  ADDR_W  icache read address
- icache_req  in  1  icache read request, level, held until icache_ready
- icache_rdata  out  DATA_W  read data, valid with icache_ready
- icache_ready  out  1  one-cycle completion pulse
- dcache_addr  in  ADDR_W  dcache address
- dcache_wdata  in  DATA_W  write data
- dcache_wmask  in  DATA_W/8  byte write mask
- dcache_wen  in  1  write request, level, held until dcache_ready
- dcache_ren  in  1  read request, level, held until dcache_ready
- dcache_rdata  out  DATA_W  read data, valid with dcache_ready
- dcache_ready  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  nonzero for exactly one cycle = write issue
- mem_rstrb  out  1  one-cycle read issue pulse
- mem_rdata  in  DATA_W  memory read data
- mem_rbusy  in  1  read in progress
- mem_wbusy  in  1  write in progress

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request, pick winner, register grant, address, wdata, wmask, op (read/write) → ISSUE. No request → stay.
- dcache request = dcache_wen | dcache_ren; wen takes precedence if both set.
- dcache write with wmask == 0: no memory access; IDLE → RESP directly.
- ISSUE: mem_rstrb=1 (read) or mem_wmask=registered mask (write) for exactly this cycle; mem_addr/mem_wdata valid → WAIT.
- WAIT: stay while relevant busy (mem_rbusy for read, mem_wbusy for write) is 1; when 0, capture mem_rdata (reads) → RESP.
- RESP: pulse granted ready for one cycle with registered rdata; other ready stays 0 → IDLE.
- Ungranted requester waits; its request is not dropped.
- mem_addr/mem_wdata hold last registered value between transactions; rdata outputs hold last captured value.
- Reset values: all ready, mem_rstrb, mem_wmask = 0; mem_addr, mem_wdata, rdata outputs = 0; state IDLE; last-grant = icache.
- Reset mid-transaction: return to IDLE immediately, no ready pulse issued, in-flight transaction abandoned.

## Timing
- Request sampled in IDLE at cycle 0 → issue cycle 1 → WAIT cycle 2 → ready earliest cycle 3 (3-cycle minimum latency).
- Each additional busy cycle in WAIT adds one cycle.
- Busy first sampled in cycle after issue; memory must assert busy by then if not completing.
- Requester deasserts req in cycle after ready; IDLE in cycle 4 arbitrates fresh. Back-to-back throughput: one transaction per 4 cycles minimum.
- Zero-mask write: ready at cycle 1.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On simultaneous requests, grant the requester not granted last; last-grant updates on every grant. First contention after reset goes to dcache.
- Undefined: fixed priority, dcache always wins simultaneous requests; last-grant register not built.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), grant encoding (GNT_I, GNT_D), op encoding (OP_RD, OP_WR).
- Sub-module mem_arb_pick: combinational winner selection from icache_req, dcache request, last-grant; compile-time mode set by MEM_ARB_RR_EN.

## Test plan
- icache read 0x0000_0100, memory busy 2 cycles, returns 0xDEAD_BEEF → mem_rstrb one pulse at cycle 1, icache_ready at cycle 5 with 0xDEAD_BEEF, dcache_ready stays 0.
- dcache write 0x0000_2000 data 0x1234_5678 mask 4'b0011, wbusy 0 → mem_wmask=4'b0011 one cycle at cycle 1, dcache_ready cycle 3.
- Both request in same cycle, repeated 4 times → with MEM_ARB_RR_EN grants D,I,D,I; without, D,D,D,D while dcache keeps requesting.
- dcache wen with wmask 0 → no mem_rstrb/mem_wmask activity, dcache_ready at cycle 1.
- reset driven low during WAIT with mem_rbusy=1 → all outputs 0, no ready pulse; after release, new icache read completes normally in 3 cycles.
- dcache_wen and dcache_ren both 1 → write performed, mem_rstrb never pulses.
